fnd_scan_controller: RTL and testbench



---
 rtl/fnd_pkg.sv | 31 +++
 rtl/bin_to_bcd_seq.sv | 85 ++++++++
 rtl/fnd_scan_controller.sv | 72 +++++++
 tb/tb_fnd_scan_controller.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants, converter state encoding and leading-zero blanking rule
// for the 4-digit FND scan controller.
package fnd_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int BIN_W      = 14;
  localparam int BCD_W      = 4;
  localparam int MAX_VALUE  = 9999;
  localparam int BUF_W      = NUM_DIGITS * BCD_W;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_t;

  // A digit is blank when it and every more significant digit are zero;
  // digit 0 always shows so that a value of zero still displays "0".
  function automatic logic digit_blank(input logic [BUF_W-1:0] digits,
                                       input logic [1:0]       idx);
    logic [NUM_DIGITS-1:0] nz;
    logic                  blank;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nz[i] = |digits[i*BCD_W +: BCD_W];
    end
    case (idx)
      2'd1:    blank = !(nz[3] | nz[2] | nz[1]);
      2'd2:    blank = !(nz[3] | nz[2]);
      2'd3:    blank = !nz[3];
      default: blank = 1'b0;
    endcase
    return blank;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: accept in IDLE, 14 SHIFT cycles, done pulse in COMMIT
// (accept N -> done N+15). Not ready while busy; input offered then is dropped.
module bin_to_bcd_seq
  import fnd_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [BIN_W-1:0] i_data,
  output logic             o_ready,
  output logic             o_done,
  output logic [BUF_W-1:0] o_bcd
);

  conv_state_t      state, next_state;
  logic [BIN_W-1:0] bin_q;
  logic [BUF_W-1:0] bcd_q;
  logic [3:0]       shift_cnt;
  logic [BUF_W-1:0] bcd_adj;
  logic [BUF_W-1:0] bcd_shift;
  logic [BIN_W-1:0] bin_shift;
  logic [BIN_W-1:0] data_clamped;

  assign data_clamped = (i_data > BIN_W'(MAX_VALUE)) ? BIN_W'(MAX_VALUE) : i_data;

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      bcd_adj[i*BCD_W +: BCD_W] = (bcd_q[i*BCD_W +: BCD_W] >= 4'd5)
                                  ? bcd_q[i*BCD_W +: BCD_W] + 4'd3
                                  : bcd_q[i*BCD_W +: BCD_W];
    end
  end

  assign {bcd_shift, bin_shift} = {bcd_adj[BUF_W-2:0], bin_q, 1'b0};

  always_comb begin
    next_state = state;
    o_ready    = 1'b0;
    o_done     = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) next_state = SHIFT;
      end
      SHIFT: begin
        // shift_cnt still holds the pre-shift count, so 13 marks the 14th shift
        if (shift_cnt == 4'(BIN_W - 1)) next_state = COMMIT;
      end
      COMMIT: begin
        o_done     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      shift_cnt <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (i_valid) begin
            bin_q     <= data_clamped;
            bcd_q     <= '0;
            shift_cnt <= '0;
          end
        end
        SHIFT: begin
          bin_q     <= bin_shift;
          bcd_q     <= bcd_shift;
          shift_cnt <= shift_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_bcd = bcd_q;

endmodule

// File: rtl/fnd_scan_controller.sv
// Converts a binary value to BCD and time-multiplexes the four digits onto the
// FND decoder; scan outputs are registered, one digit slot per REFRESH_DIV cycles.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int REFRESH_DIV         = 100000,
  parameter bit BLANK_LEADING_ZEROS = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  input  logic [BIN_W-1:0] i_data,
  output logic             o_ready,
  output logic             o_done,
  input  logic             i_displayOn,
  output logic [1:0]       o_digitSelect,
  output logic [3:0]       o_value,
  output logic             o_en
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [BUF_W-1:0] conv_bcd;
  logic [BUF_W-1:0] digit_buf;
  logic [CNT_W-1:0] refresh_cnt;
  logic             tick;
  logic [1:0]       scan_idx;
  logic [1:0]       scan_next;
  logic             blank_next;

  bin_to_bcd_seq u_conv (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_done  (o_done),
    .o_bcd   (conv_bcd)
  );

  assign tick       = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));
  assign scan_next  = tick ? scan_idx + 2'd1 : scan_idx;
  assign blank_next = BLANK_LEADING_ZEROS && digit_blank(digit_buf, scan_next);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      refresh_cnt <= '0;
    end else if (tick) begin
      refresh_cnt <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Select, value and enable all come from scan_next so they switch together.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      digit_buf     <= '0;
      scan_idx      <= 2'd0;
      o_digitSelect <= 2'd0;
      o_value       <= 4'd0;
      o_en          <= 1'b0;
    end else begin
      scan_idx      <= scan_next;
      o_digitSelect <= scan_next;
      o_value       <= digit_buf[{scan_next, 2'b00} +: BCD_W];
      o_en          <= i_displayOn && !blank_next;
      if (o_done) digit_buf <= conv_bcd;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller: three instances (div 4 blank, div 4 no-blank,
// div 1 blank) compared every cycle against a decimal-arithmetic timing model.
module tb_fnd_scan_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [13:0] data = '0;
  logic        on = 1'b1;

  logic        rdy_a, done_a, en_a;
  logic [1:0]  sel_a;
  logic [3:0]  val_a;
  logic        rdy_b, done_b, en_b;
  logic [1:0]  sel_b;
  logic [3:0]  val_b;
  logic        rdy_c, done_c, en_c;
  logic [1:0]  sel_c;
  logic [3:0]  val_c;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fnd_scan_controller #(.REFRESH_DIV(4), .BLANK_LEADING_ZEROS(1'b1)) u_dut_a (
    .i_clk(clk), .i_reset(rst), .i_valid(vld), .i_data(data),
    .o_ready(rdy_a), .o_done(done_a), .i_displayOn(on),
    .o_digitSelect(sel_a), .o_value(val_a), .o_en(en_a));

  fnd_scan_controller #(.REFRESH_DIV(4), .BLANK_LEADING_ZEROS(1'b0)) u_dut_b (
    .i_clk(clk), .i_reset(rst), .i_valid(vld), .i_data(data),
    .o_ready(rdy_b), .o_done(done_b), .i_displayOn(on),
    .o_digitSelect(sel_b), .o_value(val_b), .o_en(en_b));

  fnd_scan_controller #(.REFRESH_DIV(1), .BLANK_LEADING_ZEROS(1'b1)) u_dut_c (
    .i_clk(clk), .i_reset(rst), .i_valid(vld), .i_data(data),
    .o_ready(rdy_c), .o_done(done_c), .i_displayOn(on),
    .o_digitSelect(sel_c), .o_value(val_c), .o_en(en_c));

  // Model: k = edges since reset; the displayed value changes 15 edges after accept.
  int k, shown, pend, commit_edge;
  bit busy;
  int exp_sel_a, exp_val_a, exp_en_a, exp_val_b, exp_en_b;
  int exp_sel_c, exp_val_c, exp_en_c, exp_ready, exp_done;

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic int digit_of(input int value, input int pos);
    return (value / pow10(pos)) % 10;
  endfunction

  function automatic bit is_blank(input int value, input int pos);
    return (pos > 0) && (value < pow10(pos));
  endfunction

  task automatic model_edge();
    int old;
    if (rst) begin
      k = 0; shown = 0; busy = 0;
      exp_sel_a = 0; exp_val_a = 0; exp_en_a = 0; exp_val_b = 0; exp_en_b = 0;
      exp_sel_c = 0; exp_val_c = 0; exp_en_c = 0;
      exp_ready = 1; exp_done = 0;
      return;
    end
    k++;
    old = shown;
    if (busy && k == commit_edge) begin
      shown = pend;
      busy  = 0;
    end else if (!busy && vld) begin
      pend        = (int'(data) > 9999) ? 9999 : int'(data);
      commit_edge = k + 15;
      busy        = 1;
    end
    exp_ready = busy ? 0 : 1;
    exp_done  = (busy && k == commit_edge - 1) ? 1 : 0;
    exp_sel_a = (k / 4) % 4;
    exp_val_a = digit_of(old, exp_sel_a);
    exp_en_a  = (on && !is_blank(old, exp_sel_a)) ? 1 : 0;
    exp_val_b = exp_val_a;
    exp_en_b  = on ? 1 : 0;
    exp_sel_c = k % 4;
    exp_val_c = digit_of(old, exp_sel_c);
    exp_en_c  = (on && !is_blank(old, exp_sel_c)) ? 1 : 0;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input int expv);
    logic [3:0] e;
    e = expv[3:0];
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s at k=%0d: observed %0d expected %0d", tag, k, obs, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("sel_a", {2'b00, sel_a}, exp_sel_a);
    chk("val_a", val_a, exp_val_a);
    chk("en_a", {3'b000, en_a}, exp_en_a);
    chk("ready_a", {3'b000, rdy_a}, exp_ready);
    chk("done_a", {3'b000, done_a}, exp_done);
    chk("sel_b", {2'b00, sel_b}, exp_sel_a);
    chk("val_b", val_b, exp_val_b);
    chk("en_b", {3'b000, en_b}, exp_en_b);
    chk("done_b", {3'b000, done_b}, exp_done);
    chk("sel_c", {2'b00, sel_c}, exp_sel_c);
    chk("val_c", val_c, exp_val_c);
    chk("en_c", {3'b000, en_c}, exp_en_c);
    chk("ready_c", {3'b000, rdy_c}, exp_ready);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input int value);
    vld  = 1'b1;
    data = 14'(value);
    step();
    vld  = 1'b0;
  endtask

  initial begin
    // Reset held for two cycles
    rst = 1'b1; vld = 1'b0; data = '0; on = 1'b1;
    steps(2);
    rst = 1'b0;
    steps(3);

    send(1234);  steps(40);
    send(7);     steps(40);
    send(12000); steps(40);
    send(0);     steps(24);

    // Offers during SHIFT are dropped; first value stays
    send(1111);
    vld = 1'b1; data = 14'd5555;
    steps(5);
    vld = 1'b0;
    steps(30);

    // Reset in the 5th SHIFT cycle aborts the conversion
    send(2468);
    steps(4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    steps(30);

    // Display off keeps scanning with enables low
    send(4321); steps(24);
    on = 1'b0;  steps(20);
    on = 1'b1;  steps(12);

    for (int i = 0; i < 900; i++) begin
      vld  = ($urandom_range(0, 3) == 0);
      data = 14'($urandom_range(0, 16383));
      on   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 4) == 0) data = 14'($urandom_range(0, 120));
      step();
    end
    vld = 1'b0;
    steps(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
